regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates one-cycle SPI and UART regfile write requests onto a single write port.
// Optional UART lockout after each SPI grant: define REGFILE_ARB_UART_LOCKOUT_EN.
module regfile_write_arbiter #(
  parameter int FILE_SIZE_BYTES = 26,
  parameter int LOCKOUT_CYCLES  = 1000
) (
  input  logic       i_clk_10,
  input  logic       i_rst,
  input  logic       i_spi_dv,
  input  logic [7:0] i_spi_addr,
  input  logic [7:0] i_spi_data,
  input  logic       i_uart_dv,
  input  logic [7:0] i_uart_addr,
  input  logic [7:0] i_uart_data,
  output logic       o_write,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_byte,
  output logic       o_grant_uart,
  output logic       o_err_addr,
  output logic [7:0] o_drop_count
);

  typedef enum logic {IDLE, WRITE} state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  localparam logic [8:0] ADDR_LIM = 9'(FILE_SIZE_BYTES);

  state_t     state;
  req_t       spi_q, uart_q, sel_req;
  logic       last_uart;
  logic       uart_elig, sel_spi, sel_uart, addr_ok;
  logic       spi_drop, uart_drop;
  logic [8:0] drop_sum;

`ifdef REGFILE_ARB_UART_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0] lock_cnt;

  assign uart_elig = uart_q.vld && (lock_cnt == '0);

  // Load wins over decrement so a fresh SPI grant restarts the full window.
  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst)                lock_cnt <= '0;
    else if (sel_spi)         lock_cnt <= LW'(LOCKOUT_CYCLES);
    else if (lock_cnt != '0)  lock_cnt <= lock_cnt - 1'b1;
  end
`else
  assign uart_elig = uart_q.vld;
`endif

  always_comb begin
    sel_spi  = 1'b0;
    sel_uart = 1'b0;
    if (state == IDLE) begin
      if (spi_q.vld && uart_elig) begin
        sel_spi  = last_uart;
        sel_uart = !last_uart;
      end else begin
        sel_spi  = spi_q.vld;
        sel_uart = !spi_q.vld && uart_elig;
      end
    end
  end

  assign sel_req   = sel_uart ? uart_q : spi_q;
  assign addr_ok   = {1'b0, sel_req.addr} < ADDR_LIM;
  // A slot being cleared this edge accepts a new request instead of dropping it.
  assign spi_drop  = i_spi_dv && spi_q.vld && !sel_spi;
  assign uart_drop = i_uart_dv && uart_q.vld && !sel_uart;
  assign drop_sum  = {1'b0, o_drop_count} + 9'(spi_drop) + 9'(uart_drop);

  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      spi_q        <= '0;
      uart_q       <= '0;
      last_uart    <= 1'b1;
      o_write      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_byte    <= '0;
      o_grant_uart <= 1'b0;
      o_err_addr   <= 1'b0;
      o_drop_count <= '0;
    end else begin
      state      <= IDLE;
      o_write    <= 1'b0;
      o_err_addr <= 1'b0;

      if (sel_spi || sel_uart) begin
        last_uart <= sel_uart;
        if (addr_ok) begin
          state        <= WRITE;
          o_write      <= 1'b1;
          o_wr_addr    <= sel_req.addr;
          o_wr_byte    <= sel_req.data;
          o_grant_uart <= sel_uart;
        end else begin
          o_err_addr <= 1'b1;
        end
      end

      if (i_spi_dv && (!spi_q.vld || sel_spi)) spi_q <= '{1'b1, i_spi_addr, i_spi_data};
      else if (sel_spi)                        spi_q.vld <= 1'b0;

      if (i_uart_dv && (!uart_q.vld || sel_uart)) uart_q <= '{1'b1, i_uart_addr, i_uart_data};
      else if (sel_uart)                          uart_q.vld <= 1'b0;

      o_drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule
